// File: rtl/rv32_instr_encoder.sv
// Streaming RV32I/M field-to-word encoder with LI expansion and an address counter.
// Optional macro RV_ENC_RANGE_CHECK_EN rejects immediates that do not fit their field.
module rv32_instr_encoder #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_li,
    input  logic [6:0]  cmd_opcode,
    input  logic [2:0]  cmd_funct3,
    input  logic [6:0]  cmd_funct7,
    input  logic [4:0]  cmd_rd,
    input  logic [4:0]  cmd_rs1,
    input  logic [4:0]  cmd_rs2,
    input  logic [31:0] cmd_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_addr,
    output logic        err
);

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_LI_LO = 1'b1;

    logic [0:0]  state_reg;
    logic        out_valid_reg;
    logic [31:0] out_instr_reg;
    logic [31:0] addr_reg;
    logic        err_reg;
    logic [4:0]  li_rd_reg;
    logic [11:0] li_lo_reg;

    logic        out_fire;
    logic        out_free;
    logic        cmd_fire;
    logic        is_shift;
    logic [31:0] enc_instr;
    logic        enc_ok;
    logic        range_bad;
    logic        reject;
    logic [19:0] li_hi;
    logic [31:0] li_lui;
    logic [31:0] li_addi_x0;
    logic [31:0] li_addi_rd;

    assign out_fire  = out_valid_reg && out_ready;
    assign out_free  = !out_valid_reg || out_ready;
    assign cmd_ready = (state_reg == ST_IDLE) && out_free;
    assign cmd_fire  = cmd_valid && cmd_ready;

    assign out_valid = out_valid_reg;
    assign out_instr = out_instr_reg;
    assign out_addr  = addr_reg;
    assign err       = err_reg;

    assign is_shift = (cmd_opcode == OPC_OP_IMM) &&
                      ((cmd_funct3 == 3'b001) || (cmd_funct3 == 3'b101));

    // Rounding the upper part by imm[11] compensates for ADDI sign-extending the low 12 bits.
    assign li_hi      = cmd_imm[31:12] + {19'd0, cmd_imm[11]};
    assign li_lui     = {li_hi, cmd_rd, OPC_LUI};
    assign li_addi_x0 = {cmd_imm[11:0], 5'd0, 3'b000, cmd_rd, OPC_OP_IMM};
    assign li_addi_rd = {li_lo_reg, li_rd_reg, 3'b000, li_rd_reg, OPC_OP_IMM};

    always_comb begin
        enc_instr = 32'd0;
        enc_ok    = 1'b0;
        case (cmd_opcode)
            OPC_LOAD, OPC_JALR: begin
                enc_instr = {cmd_imm[11:0], cmd_rs1, cmd_funct3, cmd_rd, cmd_opcode};
                enc_ok    = 1'b1;
            end
            OPC_OP_IMM: begin
                if (is_shift)
                    enc_instr = {cmd_funct7, cmd_imm[4:0], cmd_rs1, cmd_funct3, cmd_rd, cmd_opcode};
                else
                    enc_instr = {cmd_imm[11:0], cmd_rs1, cmd_funct3, cmd_rd, cmd_opcode};
                enc_ok = 1'b1;
            end
            OPC_STORE: begin
                enc_instr = {cmd_imm[11:5], cmd_rs2, cmd_rs1, cmd_funct3, cmd_imm[4:0], cmd_opcode};
                enc_ok    = 1'b1;
            end
            OPC_BRANCH: begin
                enc_instr = {cmd_imm[12], cmd_imm[10:5], cmd_rs2, cmd_rs1, cmd_funct3,
                             cmd_imm[4:1], cmd_imm[11], cmd_opcode};
                enc_ok    = 1'b1;
            end
            OPC_LUI, OPC_AUIPC: begin
                enc_instr = {cmd_imm[31:12], cmd_rd, cmd_opcode};
                enc_ok    = 1'b1;
            end
            OPC_JAL: begin
                enc_instr = {cmd_imm[20], cmd_imm[10:1], cmd_imm[11], cmd_imm[19:12],
                             cmd_rd, cmd_opcode};
                enc_ok    = 1'b1;
            end
            OPC_OP: begin
                enc_instr = {cmd_funct7, cmd_rs2, cmd_rs1, cmd_funct3, cmd_rd, cmd_opcode};
                enc_ok    = 1'b1;
            end
            OPC_SYSTEM: begin
                // Only ECALL/EBREAK are accepted; their rd/rs1 fields are architecturally zero.
                enc_instr = {cmd_imm[11:0], 5'd0, 3'b000, 5'd0, cmd_opcode};
                enc_ok    = (cmd_funct3 == 3'b000) && (cmd_imm[11:1] == 11'd0);
            end
            default: begin
                enc_instr = 32'd0;
                enc_ok    = 1'b0;
            end
        endcase
    end

`ifdef RV_ENC_RANGE_CHECK_EN
    logic signed [31:0] imm_s;
    assign imm_s = cmd_imm;

    always_comb begin
        range_bad = 1'b0;
        case (cmd_opcode)
            OPC_LOAD, OPC_JALR, OPC_STORE:
                range_bad = (imm_s < -32'sd2048) || (imm_s > 32'sd2047);
            OPC_OP_IMM:
                if (is_shift)
                    range_bad = |cmd_imm[31:5];
                else
                    range_bad = (imm_s < -32'sd2048) || (imm_s > 32'sd2047);
            OPC_BRANCH:
                range_bad = cmd_imm[0] || (imm_s < -32'sd4096) || (imm_s > 32'sd4094);
            OPC_JAL:
                range_bad = cmd_imm[0] || (imm_s < -32'sd1048576) || (imm_s > 32'sd1048574);
            OPC_LUI, OPC_AUIPC:
                range_bad = |cmd_imm[11:0];
            default:
                range_bad = 1'b0;
        endcase
    end
`else
    assign range_bad = 1'b0;
`endif

    assign reject = !enc_ok || range_bad;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            out_valid_reg <= 1'b0;
            out_instr_reg <= 32'd0;
            addr_reg      <= BASE_ADDR;
            err_reg       <= 1'b0;
            li_rd_reg     <= 5'd0;
            li_lo_reg     <= 12'd0;
        end else begin
            err_reg <= 1'b0;
            // A word loaded below in the same cycle overrides this clear.
            if (out_fire) begin
                addr_reg      <= addr_reg + 32'd4;
                out_valid_reg <= 1'b0;
            end
            case (state_reg)
                ST_IDLE: begin
                    if (cmd_fire) begin
                        if (cmd_li) begin
                            if (li_hi == 20'd0) begin
                                out_instr_reg <= li_addi_x0;
                                out_valid_reg <= 1'b1;
                            end else begin
                                out_instr_reg <= li_lui;
                                out_valid_reg <= 1'b1;
                                li_rd_reg     <= cmd_rd;
                                li_lo_reg     <= cmd_imm[11:0];
                                state_reg     <= ST_LI_LO;
                            end
                        end else if (reject) begin
                            err_reg <= 1'b1;
                        end else begin
                            out_instr_reg <= enc_instr;
                            out_valid_reg <= 1'b1;
                        end
                    end
                end
                ST_LI_LO: begin
                    if (out_free) begin
                        if (li_lo_reg != 12'd0) begin
                            out_instr_reg <= li_addi_rd;
                            out_valid_reg <= 1'b1;
                        end
                        state_reg <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/rv32_instr_encoder.md
# rv32_instr_encoder

Streaming RV32I/RV32M instruction encoder, the inverse of the core's instruction decoder. It accepts field-level commands (opcode, funct3, funct7, register indices, immediate) over a valid/ready handshake. It packs each command into a 32-bit instruction word, placing the immediate according to the format implied by the opcode (I/S/B/U/J/R). It expands an LI pseudo-command into LUI+ADDI and emits words with incrementing addresses for the boot loader, self-test generator and instruction-memory preload path.

## Interface
- BASE_ADDR, 32'h0000_0000, address of the first emitted word after reset.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_li  in  1  LI pseudo-command: load cmd_imm into cmd_rd; opcode and funct fields ignored.
- cmd_opcode  in  7  RV32 opcode (LOAD, STORE, OP_IMM, OP, LUI, AUIPC, JAL, JALR, BRANCH, SYSTEM).
- cmd_funct3  in  3  funct3 field.
- cmd_funct7  in  7  funct7 field (OP; shift-immediates use it for bits [31:25]).
- cmd_rd, cmd_rs1, cmd_rs2  in  5 each  register indices.
- cmd_imm  in  32  signed immediate (byte offset for B/J; full value for U, low 12 bits ignored).
- out_valid  out  1  out_instr/out_addr valid.
- out_ready  in  1  sink accepts word when out_valid && out_ready.
- out_instr  out  32  encoded instruction word.
- out_addr  out  32  address of out_instr.
- err  out  1  one-cycle pulse: accepted command rejected, no word emitted.

## Operation
- FSM states: IDLE, LI_LO.
- IDLE: cmd_ready = !out_valid || out_ready. LI_LO: cmd_ready = 0.
- On accept, normal command: encode combinationally, register into out_instr, set out_valid.
  - OP: R-type; funct7 taken from cmd_funct7.
  - OP_IMM with funct3 001/101: shamt = cmd_imm[4:0], bits [31:25] = cmd_funct7.
  - SYSTEM: funct3 must be 000 and cmd_imm[11:0] ∈ {0,1} (ECALL/EBREAK); rd and rs1 are forced to 0.
- Any other opcode value: err pulse, command consumed, no word emitted.
- LI: lo = sign-extended cmd_imm[11:0]; hi = (cmd_imm + 0x800) >> 12, 20 bits, mod 2^32.
  - hi == 0: emit a single ADDI rd, x0, lo.
  - Otherwise: emit LUI rd, hi, then go to LI_LO.
  - LI_LO: when the output register frees, emit ADDI rd, rd, lo if lo != 0, then return to IDLE. If lo == 0, return to IDLE without emitting.
- Address counter: resets to BASE_ADDR. It advances by 4 on each out handshake, and out_addr always shows the current counter value. Rejected commands do not advance it.
- cmd_rd == 0 is encoded as given; there is no special casing.

## Timing
- Reset values: out_valid 0, out_instr 0, out_addr BASE_ADDR, err 0, state IDLE.
- Latency: word valid the cycle after cmd acceptance. Throughput is one word per cycle under continuous out_ready.
- out_instr and out_addr hold stable while out_valid && !out_ready.
- err asserts the cycle after the offending command is accepted, for exactly one cycle.
- Simultaneous out handshake and cmd acceptance: the new word replaces the old one in the same edge, and the address advances by 4.
- Reset in any state, including LI_LO with a word pending, returns to the reset values. A pending ADDI is discarded.

## Configuration
- RV_ENC_RANGE_CHECK_EN defined: an accepted command is rejected with err, and emits nothing, if any of these hold:
  - I/S immediate is outside [-2048, 2047].
  - B immediate is outside [-4096, 4094] or odd.
  - J immediate is outside [-2^20, 2^20-2] or odd.
  - U immediate has cmd_imm[11:0] != 0.
  - shamt has cmd_imm[31:5] != 0.
- Undefined: no range checks. Immediates are truncated to field width and the low bits are dropped silently. err fires only for an invalid opcode or invalid SYSTEM fields.

## Test plan
- OP_IMM f3=000 rd=1 rs1=0 imm=5 -> out_instr 0x00500093, out_addr BASE_ADDR, next word at BASE_ADDR+4.
- BRANCH f3=000 rs1=1 rs2=2 imm=-8 -> 0xFE208CE3. OP f7=0000001 f3=000 rd=3 rs1=1 rs2=2 -> 0x022081B3.
- LI rd=5 imm=0x12345FFF -> 0x123462B7 then 0xFFF28293 on consecutive handshakes. LI rd=5 imm=7 -> single 0x00700293.
- With RV_ENC_RANGE_CHECK_EN: OP_IMM imm=2048 -> err pulse, no out_valid, out_addr unchanged. Without the macro -> word with imm field 0x800 emitted.
- out_ready held 0 for 5 cycles after a word -> out_instr/out_addr stable, cmd_ready 0. On release, back-to-back commands stream one word per cycle.
- rst asserted in LI_LO after the LUI handshake -> out_valid 0, out_addr BASE_ADDR, no ADDI emitted. The next command encodes normally.
